// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the iterative AES inverse-cipher block.
//   ctrl_state_e        controller states (IDLE, ROUND, FINAL, DONE)
//   NR_128/192/256      round counts per key size
//   BLOCK_W, RK_ADDR_W  block width and round-key index width
//   get_byte/set_byte   byte i of a block, byte 0 at the MSB end
//   get_col/set_col     column c of a block, column 0 at the MSB end
package aes_pkg;

    localparam int BLOCK_W   = 128;
    localparam int RK_ADDR_W = 4;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk, input int idx);
        return blk[BLOCK_W-1-8*idx -: 8];
    endfunction

    function automatic logic [BLOCK_W-1:0] set_byte(input logic [BLOCK_W-1:0] blk,
                                                    input int idx,
                                                    input logic [7:0] b);
        logic [BLOCK_W-1:0] res;
        res = blk;
        res[BLOCK_W-1-8*idx -: 8] = b;
        return res;
    endfunction

    function automatic logic [31:0] get_col(input logic [BLOCK_W-1:0] blk, input int col);
        return blk[BLOCK_W-1-32*col -: 32];
    endfunction

    function automatic logic [BLOCK_W-1:0] set_col(input logic [BLOCK_W-1:0] blk,
                                                   input int col,
                                                   input logic [31:0] w);
        logic [BLOCK_W-1:0] res;
        res = blk;
        res[BLOCK_W-1-32*col -: 32] = w;
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
//   state_in   [127:0]  current state (byte 0 at MSB, column-major)
//   round_key  [127:0]  round key applied after InvSubBytes
//   last       1        final round: InvMixColumns is bypassed
//   state_out  [127:0]  InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ k), or without
//                       InvMixColumns when last=1
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               last,
    output logic [BLOCK_W-1:0] state_out
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse affine map first, then field inversion; avoids a 256-entry table.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][c-r].
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] blk);
        logic [BLOCK_W-1:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                res = set_byte(res, r + 4*c, get_byte(blk, r + 4*((c - r + 4) % 4)));
            end
        end
        return res;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] blk);
        logic [BLOCK_W-1:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res = set_byte(res, i, inv_sbox(get_byte(blk, i)));
        end
        return res;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] blk);
        logic [BLOCK_W-1:0] res;
        logic [31:0]        col;
        logic [7:0]         a0, a1, a2, a3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            col = get_col(blk, c);
            a0  = col[31:24];
            a1  = col[23:16];
            a2  = col[15:8];
            a3  = col[7:0];
            res = set_col(res, c, {
                gf_mul(a0, 8'h0E) ^ gf_mul(a1, 8'h0B) ^ gf_mul(a2, 8'h0D) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0E) ^ gf_mul(a2, 8'h0B) ^ gf_mul(a3, 8'h0D),
                gf_mul(a0, 8'h0D) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0E) ^ gf_mul(a3, 8'h0B),
                gf_mul(a0, 8'h0B) ^ gf_mul(a1, 8'h0D) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0E)});
        end
        return res;
    endfunction

    logic [BLOCK_W-1:0] shifted;
    logic [BLOCK_W-1:0] subbed;
    logic [BLOCK_W-1:0] keyed;
    logic [BLOCK_W-1:0] mixed;

    assign shifted   = inv_shift_rows(state_in);
    assign subbed    = inv_sub_bytes(shifted);
    assign keyed     = subbed ^ round_key;
    assign mixed     = inv_mix_columns(keyed);
    assign state_out = last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES inverse cipher, one round per clock.
//   clk, rst              clock, asynchronous active-high reset
//   key_valid             expanded key present in the key store (looked at in IDLE only)
//   in_valid/in_ready     ciphertext handshake, data_in [127:0]
//   rk_addr [3:0]         round-key index, rk_data [127:0] returned same cycle
//   out_valid/out_ready   plaintext handshake, data_out [127:0] from the state register
//   busy                  high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for ciphertext; rk_addr=NR for the initial AddRoundKey
// ROUND | full inverse round using key rnd; leaves after rnd==1
// FINAL | last round (key 0), InvMixColumns bypassed
// DONE  | plaintext presented until out_ready
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   data_in,
    output logic [RK_ADDR_W-1:0] rk_addr,
    input  logic [BLOCK_W-1:0]   rk_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLOCK_W-1:0]   data_out,
    output logic                 busy
);

    localparam logic [RK_ADDR_W-1:0] NR_ADDR   = RK_ADDR_W'(NR);
    localparam logic [RK_ADDR_W-1:0] FIRST_RND = RK_ADDR_W'(NR - 1);
    localparam logic [RK_ADDR_W-1:0] ONE       = RK_ADDR_W'(1);

    ctrl_state_e          fsm_state;
    ctrl_state_e          fsm_next;
    logic [RK_ADDR_W-1:0] rnd;
    logic [RK_ADDR_W-1:0] rnd_next;
    logic [BLOCK_W-1:0]   state_reg;
    logic [BLOCK_W-1:0]   state_reg_next;
    logic [BLOCK_W-1:0]   round_out;
    logic                 last_round;

    assign last_round = (fsm_state == FINAL);
    assign data_out   = state_reg;

    aes_inv_round u_inv_round (
        .state_in  (state_reg),
        .round_key (rk_data),
        .last      (last_round),
        .state_out (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state <= IDLE;
            rnd       <= '0;
            state_reg <= '0;
        end else begin
            fsm_state <= fsm_next;
            rnd       <= rnd_next;
            state_reg <= state_reg_next;
        end
    end

    always_comb begin
        fsm_next       = fsm_state;
        rnd_next       = rnd;
        state_reg_next = state_reg;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        busy           = 1'b1;
        rk_addr        = rnd;
        unique case (fsm_state)
            IDLE: begin
                busy     = 1'b0;
                rk_addr  = NR_ADDR;
                in_ready = key_valid;
                if (in_valid && key_valid) begin
                    state_reg_next = data_in ^ rk_data;
                    rnd_next       = FIRST_RND;
                    fsm_next       = ROUND;
                end
            end
            ROUND: begin
                rk_addr        = rnd;
                state_reg_next = round_out;
                rnd_next       = rnd - ONE;
                if (rnd == ONE) fsm_next = FINAL;
            end
            FINAL: begin
                rk_addr        = '0;
                state_reg_next = round_out;
                fsm_next       = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Testbench for aes_inv_cipher_ctrl. The reference is an AES forward cipher
// with key expansion: random plaintexts are encrypted here and the DUT must
// decrypt them back. FIPS-197 C.1 and C.3 vectors are checked as constants.
module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] REF_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         key_valid, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] data_in, data_out, rk_data;
    logic [3:0]   rk_addr;
    logic [127:0] ks10 [0:15];

    logic         key_valid_14, in_valid_14, in_ready_14, out_valid_14, out_ready_14, busy_14;
    logic [127:0] data_in_14, data_out_14, rk_data_14;
    logic [3:0]   rk_addr_14;
    logic [127:0] ks14 [0:15];

    assign rk_data    = ks10[rk_addr];
    assign rk_data_14 = ks14[rk_addr_14];

    aes_inv_cipher_ctrl #(.NR(10)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .rk_addr(rk_addr), .rk_data(rk_data), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    aes_inv_cipher_ctrl #(.NR(14)) dut14 (
        .clk(clk), .rst(rst), .key_valid(key_valid_14), .in_valid(in_valid_14),
        .in_ready(in_ready_14), .data_in(data_in_14), .rk_addr(rk_addr_14),
        .rk_data(rk_data_14), .out_valid(out_valid_14), .out_ready(out_ready_14),
        .data_out(data_out_14), .busy(busy_14)
    );

    // ---------------- reference model ----------------
    logic [7:0]   sbox [0:255];
    logic [127:0] rk_model [0:15];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the multiplicative group with generator 3 (p) and its inverse (q).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int          nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] ct;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_model[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row+4*col] = t[row + 4*((col+row) % 4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_model[r][127-8*i -: 8];
        end
        ct = '0;
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    // ---------------- drivers (no checking) ----------------
    task automatic send10(input logic [127:0] ct, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = ct;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send14(input logic [127:0] ct, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_valid_14 = 1'b1;
        data_in_14  = ct;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready_14) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid_14 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_kv1: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        n_checks++; if (rk_addr !== 4'd10) begin n_fail++; $display("FAIL reset_rk_addr: got %0d expected 10", rk_addr); end
        n_checks++; if (rk_addr_14 !== 4'd14) begin n_fail++; $display("FAIL reset_rk_addr_14: got %0d expected 14", rk_addr_14); end
        key_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_kv0: got %b expected 0", in_ready); end
        key_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fips_c1();
        bit ok;
        int lat;
        expand_key(C1_KEY, 10);
        for (int r = 0; r <= 10; r++) ks10[r] = rk_model[r];
        key_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (rk_addr !== 4'd10) begin n_fail++; $display("FAIL c1_rk_addr_idle: got %0d expected 10", rk_addr); end
        send10(C1_CT, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL c1_accept: got no accept expected accept"); end
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
            if (k < 10) begin
                n_checks++;
                if (rk_addr !== 4'(9 - k)) begin n_fail++; $display("FAIL c1_rk_addr_seq: got %0d expected %0d", rk_addr, 9 - k); end
            end
        end
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL c1_latency: got %0d expected 10", lat); end
        n_checks++; if (data_out !== REF_PT) begin n_fail++; $display("FAIL c1_data_out: got %h expected %h", data_out, REF_PT); end
    endtask

    // Continues from test_fips_c1: the block has just been presented.
    task automatic test_backpressure();
        for (int j = 0; j < 5; j++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_held: got %b expected 1", out_valid); end
            n_checks++; if (data_out !== REF_PT) begin n_fail++; $display("FAIL bp_data_held: got %h expected %h", data_out, REF_PT); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
            @(negedge clk);
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_6th: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid_after: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after: got %b expected 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_key_valid();
        int lat;
        key_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = C1_CT;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL kv_in_ready_low: got %b expected 0", in_ready); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kv_busy_low: got %b expected 0", busy); end
            @(negedge clk);
        end
        key_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kv_in_ready_rise: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kv_accept_busy: got %b expected 1", busy); end
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL kv_latency: got %0d expected 10", lat); end
        n_checks++; if (data_out !== REF_PT) begin n_fail++; $display("FAIL kv_data_out: got %h expected %h", data_out, REF_PT); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int           n_acc, n_out, acc0, acc1;
        logic [127:0] o0, o1;
        n_acc = 0; n_out = 0; acc0 = -1; acc1 = -1; o0 = '0; o1 = '0;
        out_ready = 1'b1;
        key_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = C1_CT;
        for (int n = 0; n < 80 && (n_acc < 2 || n_out < 2); n++) begin
            if (n > 0) @(negedge clk);
            if (in_valid && in_ready) begin
                if (n_acc == 0) acc0 = n; else acc1 = n;
                n_acc++;
            end else if (n_acc == 2) begin
                in_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (n_out == 0) o0 = data_out; else o1 = data_out;
                n_out++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (n_acc != 2 || n_out != 2) begin n_fail++; $display("FAIL b2b_counts: got %0d accepts %0d outputs expected 2 and 2", n_acc, n_out); end
        n_checks++; if (acc1 - acc0 != 12) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 12", acc1 - acc0); end
        n_checks++; if (o0 !== REF_PT) begin n_fail++; $display("FAIL b2b_first_data: got %h expected %h", o0, REF_PT); end
        n_checks++; if (o1 !== REF_PT) begin n_fail++; $display("FAIL b2b_second_data: got %h expected %h", o1, REF_PT); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        out_ready = 1'b0;
        send10(C1_CT, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_accept: got no accept expected accept"); end
        for (int k = 0; k < 5; k++) @(negedge clk);
        n_checks++; if (rk_addr !== 4'd5) begin n_fail++; $display("FAIL rm_rnd5: got %0d expected 5", rk_addr); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
        n_checks++; if (rk_addr !== 4'd10) begin n_fail++; $display("FAIL rm_rk_addr: got %0d expected 10", rk_addr); end
        n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL rm_data_out: got %h expected 0", data_out); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send10(C1_CT, ok);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        n_checks++; if (!ok || lat != 10) begin n_fail++; $display("FAIL rm_fresh_latency: got %0d expected 10", lat); end
        n_checks++; if (data_out !== REF_PT) begin n_fail++; $display("FAIL rm_fresh_data: got %h expected %h", data_out, REF_PT); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit           ok;
        int           lat, hold;
        logic [255:0] key;
        logic [127:0] pt, ct;
        for (int it = 0; it < 4; it++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_key(key, 10);
            for (int r = 0; r <= 10; r++) ks10[r] = rk_model[r];
            ct   = encrypt(pt, 10);
            hold = int'($urandom_range(0, 3));
            out_ready = 1'b0;
            send10(ct, ok);
            lat = -1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (out_valid) begin lat = k; break; end
            end
            n_checks++; if (!ok || lat != 10) begin n_fail++; $display("FAIL rand_latency: got %0d expected 10", lat); end
            for (int h = 0; h < hold; h++) @(negedge clk);
            n_checks++; if (data_out !== pt) begin n_fail++; $display("FAIL rand_data: got %h expected %h", data_out, pt); end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_handshake: got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_nr14();
        bit           ok;
        int           lat;
        logic [255:0] key;
        logic [127:0] pt, ct;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                key = C3_KEY;
                pt  = REF_PT;
            end else begin
                key = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            expand_key(key, 14);
            for (int r = 0; r <= 14; r++) ks14[r] = rk_model[r];
            ct = (it == 0) ? C3_CT : encrypt(pt, 14);
            key_valid_14 = 1'b1;
            out_ready_14 = 1'b0;
            send14(ct, ok);
            lat = -1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (out_valid_14) begin lat = k; break; end
            end
            n_checks++; if (!ok || lat != 14) begin n_fail++; $display("FAIL nr14_latency: got %0d expected 14", lat); end
            n_checks++; if (data_out_14 !== pt) begin n_fail++; $display("FAIL nr14_data: got %h expected %h", data_out_14, pt); end
            n_checks++; if (busy_14 !== 1'b1) begin n_fail++; $display("FAIL nr14_busy_done: got %b expected 1", busy_14); end
            out_ready_14 = 1'b1;
            @(negedge clk);
            out_ready_14 = 1'b0;
        end
    endtask

    initial begin
        rst          = 1'b0;
        key_valid    = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        data_in      = '0;
        key_valid_14 = 1'b1;
        in_valid_14  = 1'b0;
        out_ready_14 = 1'b0;
        data_in_14   = '0;
        for (int i = 0; i < 16; i++) begin
            ks10[i] = '0;
            ks14[i] = '0;
        end
        build_sbox();
        #2 rst = 1'b1;
        test_reset();
        test_fips_c1();
        test_backpressure();
        test_key_valid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_nr14();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES inverse-cipher controller that sequences one decryption round per clock through the existing combinational inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns). It accepts a ciphertext block over a valid/ready handshake and fetches round keys from an externally expanded key store. It holds the 128-bit state register and round counter, and returns the plaintext over a second valid/ready handshake. It sits between the block-level I/O wrapper and the round-key register file.

## Interface
- NR, 10, number of cipher rounds; legal values 10, 12, 14 (AES-128/192/256).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  round-key store holds a complete expanded key; sampled only in IDLE.
- in_valid  in  1  ciphertext offered.
- in_ready  out  1  `(state==IDLE) & key_valid`.
- data_in  in  128  ciphertext; byte 0 at [127:120], column-major, column c at [127-32c -: 32].
- rk_addr  out  4  round-key index requested this cycle.
- rk_data  in  128  round key at rk_addr, combinational, same-cycle read.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- data_out  out  128  plaintext; same byte order as data_in; driven from the state register.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ROUND, FINAL, DONE. Round counter `rnd` is 4 bits.
- IDLE:
  - rk_addr = NR.
  - On `in_valid & in_ready`: state_reg <= data_in ^ rk_data, rnd <= NR-1, go to ROUND.
- ROUND:
  - rk_addr = rnd.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_data).
  - rnd <= rnd-1.
  - Go to FINAL when rnd==1.
- FINAL:
  - rk_addr = 0.
  - state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk_data, with no InvMixColumns.
  - Go to DONE.
- DONE:
  - out_valid=1; data_out and state_reg held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in DONE.
- key_valid is not monitored after accept. The key store must keep rk_data stable for all addresses until out_valid&out_ready.
- All byte arithmetic is GF(2^8) mod 0x11B and lives inside the datapath. The controller adds only XOR and the counter decrement.
- in_valid while not in_ready is ignored; data_in is not captured.
- out_ready while out_valid=0 has no effect.
- Reset at any point, including mid-round or in DONE with out_ready high:
  - immediately forces IDLE, rnd=0, state_reg=0;
  - out_valid=0, busy=0, rk_addr=NR.
  - The in-flight block is discarded; no partial output.

## Timing
- Reset values: in_ready=key_valid, out_valid=0, busy=0, data_out=0, rk_addr=NR.
- Latency: with accept on edge E, out_valid rises after edge E+NR (10 cycles for NR=10).
- With out_ready held high, DONE lasts 1 cycle. IDLE is re-entered after E+NR+1, and the next accept is earliest at edge E+NR+2, giving one block per NR+2 cycles.
- data_out is stable from out_valid rise until the handshake edge.
- rk_addr is a pure function of state and rnd; no glitch-sensitive paths leave the block.

## Structure
- Shared package aes_pkg holds:
  - state enum (IDLE, ROUND, FINAL, DONE);
  - NR constants for 128/192/256;
  - BLOCK_W=128 and RK_ADDR_W=4;
  - byte/column slice helper functions matching the codebase's MSB-first byte order.
- One sub-module, aes_inv_round: purely combinational.
  - Inputs: state, round key, final flag.
  - Instantiates InvShiftRows, InvSubBytes and InvMixColumns.
  - Muxes out InvMixColumns when final=1.
- The controller holds only the FSM, rnd, state_reg and handshakes.

## Test plan
- FIPS-197 C.1 vector, NR=10, key 000102030405060708090a0b0c0d0e0f, expanded key preloaded into a bench key store:
  - ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a accepted;
  - out_valid exactly 10 cycles later;
  - data_out = 00112233445566778899aabbccddeeff;
  - rk_addr sequence 10,9,…,1,0.
- Backpressure: out_ready low for 5 cycles after out_valid.
  - data_out and out_valid held; in_ready=0 throughout.
  - Handshake on the 6th cycle, then in_ready returns the next cycle.
- key_valid=0 with in_valid=1 for 4 cycles: no accept, busy=0. Raising key_valid gives an accept on the next edge.
- Back-to-back: two C.1 blocks with out_ready=1. Second accept is exactly 12 cycles after the first; both outputs are correct.
- Reset asserted mid-block (during the ROUND with rnd=5):
  - asynchronously gives out_valid=0, busy=0, rk_addr=10.
  - After release, a fresh C.1 block decrypts correctly.
- NR=14 with the FIPS-197 C.3 vector:
  - ciphertext 8ea2b7ca516745bfeafc49904b496089 gives 00112233445566778899aabbccddeeff;
  - latency 14 cycles.
